// File: rtl/bcd_display_pkg.sv
// Shared types and helpers for the BCD accumulator display.
// Seven-segment table, FSM states and width helpers.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    OUT
  } state_t;

  localparam logic [6:0] SEG7 [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg7_enc(
    input logic [3:0] n
  );
    return (n < 4'd10) ? SEG7[n] : 7'h00;
  endfunction

  function automatic int pow10(input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic int acc_w_of(input int d);
    return $clog2(pow10(d));
  endfunction

  function automatic int max_of(input int d);
    return pow10(d) - 1;
  endfunction

endpackage

// File: rtl/bcd_accum_display_if.sv
// Valid/ready stream with one sideband bit.
// user carries s_clear on input, m_ovf on output.
interface bcd_accum_display_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         user;

  modport master (
    output valid,
    output data,
    output user,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  user,
    output ready
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter.
// bcd_nxt is the value after the current cycle's shift.
module bin2bcd_serial
  import bcd_display_pkg::*;
#(
  parameter int ACC_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ACC_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_nxt
);

  localparam int CW = $clog2(ACC_W + 1);
  localparam int DW = DIGITS * 4;

  logic [ACC_W-1:0] sr;
  logic [DW-1:0]    bcd;
  logic [DW-1:0]    adj;
  logic [CW-1:0]    cnt;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i+:4] >= 4'd5)
        adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
      else
        adj[4*i+:4] = bcd[4*i+:4];
    end
  end

  // top nibble never overflows: value fits in DIGITS digits
  assign bcd_nxt = (adj << 1) | DW'(sr[ACC_W-1]);
  assign busy    = (cnt != '0);
  assign done    = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= CW'(ACC_W);
    end else if (busy) begin
      sr  <= sr << 1;
      bcd <= bcd_nxt;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/bcd_accum_display.sv
// Saturating stream accumulator shown as seven-segment digits.
// Define BCD_ACCUM_BLANK_LZ_EN to blank leading zeros.
module bcd_accum_display
  import bcd_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input logic                  clk,
  input logic                  rstn,
  bcd_accum_display_if.slave   s,
  bcd_accum_display_if.master  m
);

  localparam int ACC_W = acc_w_of(DIGITS);
  localparam int MAX   = max_of(DIGITS);
  localparam int SW    =
    ((ACC_W > WIDTH) ? ACC_W : WIDTH) + 1;
  localparam logic [SW-1:0] MAX_W = SW'(MAX);

  state_t                   state;
  logic [ACC_W-1:0]         sum;
  logic [ACC_W-1:0]         sum_new;
  logic [SW-1:0]            nxt;
  logic                     sat;
  logic                     accept;
  logic                     ovf;
  logic                     valid_q;
  logic                     busy;
  logic                     done;
  logic [DIGITS*4-1:0]      bcd;
  logic [DIGITS-1:0][6:0]   seg;
  logic [DIGITS-1:0][6:0]   seg_q;

  assign s.ready = (state == IDLE);
  assign accept  = s.valid && s.ready;

  assign nxt     = (s.user ? '0 : SW'(sum)) + SW'(s.data);
  assign sat     = (nxt > MAX_W);
  assign sum_new = sat ? ACC_W'(MAX) : nxt[ACC_W-1:0];

  bin2bcd_serial #(
    .ACC_W  (ACC_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rstn    (rstn),
    .start   (accept),
    .bin     (sum_new),
    .busy    (busy),
    .done    (done),
    .bcd_nxt (bcd)
  );

`ifdef BCD_ACCUM_BLANK_LZ_EN
  always_comb begin
    logic lead;
    lead = 1'b1;
    seg  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (lead && (bcd[4*i+:4] == 4'd0) && (i != 0)) begin
        seg[i] = 7'h00;
      end else begin
        lead   = 1'b0;
        seg[i] = seg7_enc(bcd[4*i+:4]);
      end
    end
  end
`else
  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++)
      seg[i] = seg7_enc(bcd[4*i+:4]);
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sum     <= '0;
      ovf     <= 1'b0;
      valid_q <= 1'b0;
      seg_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sum   <= sum_new;
            state <= CONV;
            if (sat)
              ovf <= 1'b1;
            else if (s.user)
              ovf <= 1'b0;
          end
        end
        CONV: begin
          if (done) begin
            state   <= OUT;
            valid_q <= 1'b1;
            seg_q   <= seg;
          end else if (!busy) begin
            state <= IDLE;
          end
        end
        OUT: begin
          if (m.ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m.valid = valid_q;
  assign m.data  = seg_q;
  assign m.user  = ovf;

endmodule

// File: tb/tb_bcd_accum_display.sv
// Bench for bcd_accum_display at DIGITS=3, WIDTH=8.
// Reference model works on decimal integers.
module tb_bcd_accum_display;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int MW     = DIGITS * 7;
  localparam int LAT    = 10;
  localparam int MAXV   = 999;

  localparam logic [6:0] SEGS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic clk;
  logic rstn;

  bcd_accum_display_if #(.W(WIDTH)) s_if ();
  bcd_accum_display_if #(.W(MW))    m_if ();

  bcd_accum_display #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (s_if),
    .m    (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int ref_sum;
  bit ref_ovf;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] exp_disp(input int v);
    logic [MW-1:0] r;
    logic [6:0]    sg;
    int            p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      sg = SEGS[(v / p) % 10];
`ifdef BCD_ACCUM_BLANK_LZ_EN
      if (i > 0 && v < p) sg = 7'h00;
`endif
      r[i*7+:7] = sg;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model(input int d, input bit clr);
    ref_sum = clr ? d : ref_sum + d;
    if (ref_sum > MAXV) begin
      ref_sum = MAXV;
      ref_ovf = 1'b1;
    end else if (clr) begin
      ref_ovf = 1'b0;
    end
  endtask

  task automatic send(
    input int d,
    input bit clr,
    input bit mrdy
  );
    int lat;
    @(negedge clk);
    check("s_ready_idle", 32'(s_if.ready), 32'd1);
    s_if.valid = 1'b1;
    s_if.data  = 8'(d);
    s_if.user  = clr;
    m_if.ready = mrdy;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.user  = 1'b0;
    model(d, clr);
    check("s_ready_conv", 32'(s_if.ready), 32'd0);
    lat = 0;
    while (!m_if.valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("m_data", 32'(m_if.data), 32'(exp_disp(ref_sum)));
    check("m_ovf", 32'(m_if.user), 32'(ref_ovf));
  endtask

  task automatic handshake();
    m_if.ready = 1'b1;
    @(posedge clk);
    #1;
    check("hs_m_valid", 32'(m_if.valid), 32'd0);
    check("hs_s_ready", 32'(s_if.ready), 32'd1);
    m_if.ready = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] held;
    bit            seen;
    int            d;
    bit            c;
    tests      = 0;
    fails      = 0;
    ref_sum    = 0;
    ref_ovf    = 1'b0;
    rstn       = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.user  = 1'b0;
    m_if.ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_if.ready), 32'd1);
    check("rst_m_valid", 32'(m_if.valid), 32'd0);
    check("rst_m_ovf", 32'(m_if.user), 32'd0);
    check("rst_m_data", 32'(m_if.data), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    send(5, 1'b0, 1'b1);
    handshake();
    send(7, 1'b0, 1'b1);
    handshake();

    send(30, 1'b0, 1'b0);
    held = m_if.data;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = 8'd77;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_m_valid", 32'(m_if.valid), 32'd1);
      check("bp_m_data", 32'(m_if.data), 32'(held));
      check("bp_s_ready", 32'(s_if.ready), 32'd0);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
    handshake();
    send(1, 1'b0, 1'b1);
    handshake();

    send(255, 1'b1, 1'b1);
    handshake();
    for (int i = 0; i < 3; i++) begin
      send(255, 1'b0, 1'b1);
      handshake();
    end
    send(3, 1'b1, 1'b1);
    handshake();
    send(0, 1'b1, 1'b1);
    handshake();

    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 255));
      c = ($urandom_range(0, 4) == 0);
      send(d, c, 1'b1);
      handshake();
    end

    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = 8'd100;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_m_valid", 32'(m_if.valid), 32'd0);
    check("mid_s_ready", 32'(s_if.ready), 32'd1);
    check("mid_m_data", 32'(m_if.data), 32'd0);
    check("mid_m_ovf", 32'(m_if.user), 32'd0);
    ref_sum = 0;
    ref_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (m_if.valid) seen = 1'b1;
    end
    check("mid_no_valid", 32'(seen), 32'd0);
    send(9, 1'b0, 1'b1);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_accum_display.md
# bcd_accum_display

Streaming accumulator that sums unsigned input beats and presents the running total as DIGITS decimal seven-segment patterns. It is the multi-digit successor of the two-digit adder/display block. It sits between an AXI-Stream-style producer and the display multiplexer. Binary-to-BCD conversion is sequential (shift-add-3), so no divider is required at any DIGITS value.

## Interface
Parameters:
- WIDTH, 8: input beat width (unsigned).
- DIGITS, 4: number of decimal digits displayed; range 1..8.
- Derived ACC_W = $clog2(10**DIGITS): accumulator width. MAX = 10**DIGITS - 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  WIDTH  value to add.
- s_clear  in  1  sideband, sampled with the beat: the sum restarts from s_data.
- m_valid  out  1  display data valid.
- m_ready  in  1  consumer accepts the display data.
- m_data  out  [DIGITS-1:0][6:0]  segments gfedcba, active-high; [0] is the least significant digit.
- m_ovf  out  1  sticky saturation flag.

## Operation
- FSM states:
  - IDLE: s_ready=1.
  - CONV: s_ready=0; performs shifts.
  - OUT: m_valid=1.
- s_ready is decoded combinationally as state==IDLE.
- Accept: on an edge with s_valid && s_ready.
  - Next sum = s_clear ? s_data : sum + s_data, computed ACC_W+1 bits wide.
  - If the next sum exceeds MAX: sum = MAX and m_ovf = 1.
  - s_clear also clears m_ovf, unless the new value itself exceeds MAX.
  - The new sum is loaded into the shift register, BCD digits are zeroed, the shift counter is set to ACC_W, and the FSM enters CONV.
- CONV: one shift per cycle. Any BCD nibble ≥5 gets +3 before the shift. The counter decrements each cycle; the last shift moves the FSM to OUT.
- On entry to OUT, m_data is registered from the BCD nibbles through the segment encoder.
- Segment encoding: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any other nibble gives 00 (unreachable).
- OUT: m_valid, m_data and m_ovf are held stable until m_valid && m_ready, then the FSM returns to IDLE. m_data keeps its last value after the handshake.
- s_valid asserted outside IDLE is ignored; the beat stays pending at the source.
- Reset (any state, including mid-CONV): sum=0, state=IDLE, m_valid=0, m_ovf=0, m_data all 7'h00. Conversion in flight is discarded; no m_valid is produced.

## Timing
- Latency: accept edge E0 → m_valid high after edge E0+ACC_W.
- Minimum beat period with m_ready held high: ACC_W+2 cycles.
- m_valid never drops without a handshake.
- m_ready has no effect outside OUT.

## Configuration
- Macro: BCD_ACCUM_BLANK_LZ_EN.
- Defined: leading-zero blanking. Every digit above the most significant non-zero digit outputs 7'h00. Digit [0] always shows, so a value of 0 displays as 3F.
- Undefined: all digits show, leading zeros appear as 3F.

## Structure
- Package bcd_display_pkg holds:
  - the seg7 constant array and the encode function;
  - the FSM state enum typedef;
  - a function for ACC_W/MAX from DIGITS.
- Sub-module bin2bcd_serial (parameters ACC_W, DIGITS): start/busy/done interface, shift-add-3 datapath, counter.
- The top level owns the handshake FSM, accumulator, saturation and segment registers.

## Test plan
All scenarios use DIGITS=3, WIDTH=8, so ACC_W=10 and MAX=999.
- Reset check: assert reset → s_ready=1, m_valid=0, m_ovf=0, m_data={00,00,00}.
- Basic accumulation: send 5 then 7, m_ready=1 → second result m_data={3F,06,5B} (012). m_valid rises 10 cycles after the accept; s_ready is low throughout CONV/OUT.
- Backpressure: hold m_ready=0 for 20 cycles in OUT while s_valid=1 → m_valid, m_data stable; s_ready=0; no beat consumed. Release → one handshake, then IDLE.
- Saturation and clear: send 255 four times → 999 (6F,6F,6F), m_ovf=1. Then send 3 with s_clear=1 → 003, m_ovf=0.
- Reset mid-CONV: deassert rstn 4 cycles after an accept → no m_valid. After release the sum is 0; sending 9 yields 009.
- With BCD_ACCUM_BLANK_LZ_EN: a sum of 12 → {00,06,5B}; a cleared sum of 0 → {00,00,3F}.
